// File: rtl/split_mem_target.sv
// -----------------------------------------------------------------------------
// split_mem_target
//
// Bus target with an internal byte-wide memory. Writes finish with a single
// ack. Reads are split: the target acks the address with s_split_ack and
// releases the bus. It waits READ_LATENCY cycles, then raises split_req and
// holds it until split_grant arrives. The read data is returned one cycle
// after the grant.
//
// Parameters
//   INTERNAL_ADDR_BITS : word-address width of the memory (2^N bytes)
//   READ_LATENCY       : idle cycles between split release and re-request (0..15)
//
// Ports
//   clk                 in   sole clock, rising edge
//   rst                 in   synchronous, active-high reset
//   s_address_in[15:0]  in   bus address, upper bits beyond the memory are dropped
//   s_address_in_valid  in   address qualifier
//   s_data_in[7:0]      in   write data
//   s_data_in_valid     in   write-data qualifier
//   s_rw                in   1 = write, 0 = read
//   split_grant         in   bus grant answering split_req
//   s_data_out[7:0]     out  read data, holds the last value read
//   s_data_out_valid    out  one-cycle read-data qualifier
//   s_ack               out  one-cycle transfer-complete pulse
//   s_split_ack         out  one-cycle pulse: read accepted as split
//   s_ready             out  idle and able to accept an address
//   split_req           out  request to reclaim the bus for read completion
//   split_s_last_write  out  most recent byte written to memory
// -----------------------------------------------------------------------------
module split_mem_target #(
  parameter int unsigned INTERNAL_ADDR_BITS = 12,
  parameter int unsigned READ_LATENCY       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_address_in,
  input  logic        s_address_in_valid,
  input  logic [7:0]  s_data_in,
  input  logic        s_data_in_valid,
  input  logic        s_rw,
  input  logic        split_grant,
  output logic [7:0]  s_data_out,
  output logic        s_data_out_valid,
  output logic        s_ack,
  output logic        s_split_ack,
  output logic        s_ready,
  output logic        split_req,
  output logic [7:0]  split_s_last_write
);

  localparam int unsigned AW    = INTERNAL_ADDR_BITS;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [3:0]  LAT   = 4'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_SPLIT,
    S_RD_WAIT,
    S_RD_REQ,
    S_RD_DATA
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      last_wr_q, last_wr_d;
  logic [7:0]      rdata_q;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic            rd_en;

  logic [7:0]      mem_q [DEPTH];

  // Address bits above the memory width are discarded, so aliases such as
  // 0x1004 and 0x0004 reach the same byte.
  if (AW < 16) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^s_address_in[15:AW];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    last_wr_d = last_wr_q;
    wr_en     = 1'b0;
    wr_addr   = addr_q;
    rd_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (s_address_in_valid) begin
          addr_d = s_address_in[AW-1:0];
          if (s_rw) begin
            // Data that arrives with the address is written in the accept
            // cycle, so the write skips WR_DATA.
            if (s_data_in_valid) begin
              wr_en     = 1'b1;
              wr_addr   = s_address_in[AW-1:0];
              last_wr_d = s_data_in;
              state_d   = S_WR_ACK;
            end else begin
              state_d = S_WR_DATA;
            end
          end else begin
            state_d = S_RD_SPLIT;
          end
        end
      end

      S_WR_DATA: begin
        if (s_data_in_valid) begin
          wr_en     = 1'b1;
          last_wr_d = s_data_in;
          state_d   = S_WR_ACK;
        end
      end

      S_WR_ACK: state_d = S_IDLE;

      S_RD_SPLIT: begin
        cnt_d   = LAT;
        state_d = (LAT == 4'd0) ? S_RD_REQ : S_RD_WAIT;
      end

      S_RD_WAIT: begin
        // Leave on the cycle the count hits zero, so the FSM spends exactly
        // READ_LATENCY cycles here.
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = S_RD_REQ;
      end

      S_RD_REQ: begin
        if (split_grant) begin
          rd_en   = 1'b1;
          state_d = S_RD_DATA;
        end
      end

      S_RD_DATA: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      last_wr_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
    end
  end

  // The read port is registered and loaded on the grant edge. rdata_q then
  // holds its value until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem_q[addr_q];
    end
  end

  // NOTE: the storage array has no reset. Its contents survive rst; only the
  // write strobe is blocked while rst is high, so an aborted write is lost.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_addr] <= s_data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from state only)
  // ---------------------------------------------------------------------------
  assign s_ready            = (state_q == S_IDLE);
  assign s_ack              = (state_q == S_WR_ACK) || (state_q == S_RD_DATA);
  assign s_data_out_valid   = (state_q == S_RD_DATA);
  assign s_split_ack        = (state_q == S_RD_SPLIT);
  assign split_req          = (state_q == S_RD_REQ);
  assign s_data_out         = rdata_q;
  assign split_s_last_write = last_wr_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_req_held : assert property (@(posedge clk) disable iff (rst)
    (split_req && !split_grant) |=> split_req);

  a_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0({s_ack, s_split_ack, split_req}));

  a_valid_ack : assert property (@(posedge clk) disable iff (rst)
    s_data_out_valid |-> s_ack);

endmodule

// File: tb/tb_split_mem_target.sv
// -----------------------------------------------------------------------------
// tb_split_mem_target
//
// Two targets are instantiated: one with READ_LATENCY=4 (sel=0) and one with
// READ_LATENCY=0 (sel=1). A single driver talks to whichever one is selected.
// The driver pushes the expected events into a scoreboard queue: the split
// ack, the write ack and the read data, each with its cycle number. A monitor
// pops an entry and compares it each time the selected target shows an event.
// The reference model is a plain byte array per instance plus the latency
// formulas.
// -----------------------------------------------------------------------------
module tb_split_mem_target;

  localparam int AW = 12;

  typedef enum int {EV_WR_ACK, EV_SPLIT_ACK, EV_RD_DATA} ev_t;
  typedef struct {
    ev_t        kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic        addr_valid = 1'b0;
  logic [7:0]  wdata = '0;
  logic        wdata_valid = 1'b0;
  logic        rw = 1'b0;
  logic        grant = 1'b0;
  bit          sel = 1'b0;

  logic [7:0] d4_dout, d0_dout, d4_last, d0_last;
  logic       d4_dvalid, d0_dvalid, d4_ack, d0_ack, d4_sack, d0_sack;
  logic       d4_ready, d0_ready, d4_req, d0_req;

  logic [7:0] s_data_out, split_s_last_write;
  logic       s_data_out_valid, s_ack, s_split_ack, s_ready, split_req;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  logic [7:0]    model_mem [2][1 << AW];
  logic [AW-1:0] wr_list0[$];
  logic [AW-1:0] wr_list1[$];
  logic [7:0]    last_rd [2];

  split_mem_target #(.INTERNAL_ADDR_BITS(AW), .READ_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_address_in(addr), .s_address_in_valid(addr_valid && (sel == 1'b0)),
    .s_data_in(wdata), .s_data_in_valid(wdata_valid), .s_rw(rw),
    .split_grant(grant),
    .s_data_out(d4_dout), .s_data_out_valid(d4_dvalid), .s_ack(d4_ack),
    .s_split_ack(d4_sack), .s_ready(d4_ready), .split_req(d4_req),
    .split_s_last_write(d4_last)
  );

  split_mem_target #(.INTERNAL_ADDR_BITS(AW), .READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_address_in(addr), .s_address_in_valid(addr_valid && (sel == 1'b1)),
    .s_data_in(wdata), .s_data_in_valid(wdata_valid), .s_rw(rw),
    .split_grant(grant),
    .s_data_out(d0_dout), .s_data_out_valid(d0_dvalid), .s_ack(d0_ack),
    .s_split_ack(d0_sack), .s_ready(d0_ready), .split_req(d0_req),
    .split_s_last_write(d0_last)
  );

  assign s_data_out         = sel ? d0_dout   : d4_dout;
  assign s_data_out_valid   = sel ? d0_dvalid : d4_dvalid;
  assign s_ack              = sel ? d0_ack    : d4_ack;
  assign s_split_ack        = sel ? d0_sack   : d4_sack;
  assign s_ready            = sel ? d0_ready  : d4_ready;
  assign split_req          = sel ? d0_req    : d4_req;
  assign split_s_last_write = sel ? d0_last   : d4_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input ev_t kind, input logic [7:0] data, input int c);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("at_most_one_high", 32'($countones({s_ack, s_split_ack, split_req}) <= 1), 32'd1);
      if (s_split_ack || s_data_out_valid || s_ack) begin
        ev_t  obs;
        exp_t e;
        obs = s_split_ack ? EV_SPLIT_ACK : (s_data_out_valid ? EV_RD_DATA : EV_WR_ACK);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got event %0d at cycle %0d, required none", int'(obs), cyc);
        end else begin
          e = sb.pop_front();
          check("event_kind", 32'(int'(obs)), 32'(int'(e.kind)));
          check("event_cycle", 32'(cyc), 32'(e.cyc));
          if (e.kind == EV_RD_DATA) begin
            check("rd_data", 32'(s_data_out), 32'(e.data));
            check("rd_ack", 32'(s_ack), 32'd1);
            last_rd[sel] = e.data;
          end else if (e.kind == EV_WR_ACK) begin
            check("last_write", 32'(split_s_last_write), 32'(e.data));
          end
        end
      end
      if (!s_data_out_valid) check("dout_hold", 32'(s_data_out), 32'(last_rd[sel]));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks: all begin and end just after a falling edge
  // ---------------------------------------------------------------------------
  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("ready_timeout", 32'(s_ready), 32'd1);
  endtask

  task automatic select(input bit s);
    @(posedge clk);
    #1 sel = s;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] data, input int d);
    int c;
    wait_ready();
    c = cyc;
    addr = a; rw = 1'b1; addr_valid = 1'b1;
    wdata_valid = (d == 0);
    wdata = (d == 0) ? data : 8'($urandom);
    push_exp(EV_WR_ACK, data, c + 1 + d);
    model_mem[sel][a[AW-1:0]] = data;
    if (sel) wr_list1.push_back(a[AW-1:0]);
    else     wr_list0.push_back(a[AW-1:0]);
    for (int i = 1; i <= d; i++) begin
      @(negedge clk);
      // Spurious address traffic while the data is pending
      addr_valid  = 1'($urandom);
      addr        = 16'($urandom);
      rw          = 1'($urandom);
      wdata_valid = (i == d);
      wdata       = (i == d) ? data : 8'($urandom);
    end
    @(negedge clk);
    addr_valid = 1'b0; wdata_valid = 1'b0;
  endtask

  task automatic post_reset_checks();
    @(posedge clk);
    #1;
    sb.delete();
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    @(negedge clk);
    rst = 1'b0; addr_valid = 1'b0; wdata_valid = 1'b0; grant = 1'b0;
    check("rst_split_req", 32'(split_req), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_dvalid", 32'(s_data_out_valid), 32'd0);
    check("rst_ack", 32'(s_ack), 32'd0);
    check("rst_dout", 32'(s_data_out), 32'd0);
    check("rst_last_write", 32'(split_s_last_write), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_read(input logic [15:0] a, input int g, input bit abort);
    int c, lat, seen, first_req, n;
    bit done;
    wait_ready();
    c = cyc;
    lat = sel ? 0 : 4;
    addr = a; rw = 1'b0; addr_valid = 1'b1; wdata_valid = 1'($urandom);
    push_exp(EV_SPLIT_ACK, 8'h00, c + 1);
    push_exp(EV_RD_DATA, model_mem[sel][a[AW-1:0]], c + 3 + lat + g);
    seen = 0; first_req = -1; n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      addr_valid  = 1'($urandom);
      addr        = 16'($urandom);
      rw          = 1'($urandom);
      wdata_valid = 1'($urandom);
      if (first_req < 0 && split_req) begin
        first_req = cyc;
        check("split_req_start", 32'(cyc), 32'(c + 2 + lat));
      end
      if (first_req >= 0) begin
        check("split_req_held", 32'(split_req), 32'd1);
        if (abort && seen == 3) begin
          rst = 1'b1; grant = 1'b0; done = 1'b1;
        end else if (!abort && seen == g) begin
          grant = 1'b1; done = 1'b1;
        end else begin
          grant = 1'b0; seen++;
        end
      end else begin
        // Grants outside the request phase must be ignored
        grant = 1'($urandom);
      end
    end
    if (!done) check("read_timeout", 32'(done), 32'd1);
    if (abort) begin
      post_reset_checks();
    end else begin
      @(negedge clk);
      grant = 1'b0; addr_valid = 1'b0; wdata_valid = 1'b0;
    end
  endtask

  task automatic abort_write(input logic [15:0] a, input logic [7:0] junk);
    wait_ready();
    addr = a; rw = 1'b1; addr_valid = 1'b1; wdata_valid = 1'b0;
    @(negedge clk);
    addr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; wdata_valid = 1'b1; wdata = junk;
    post_reset_checks();
  endtask

  function automatic logic [15:0] pick_addr();
    logic [AW-1:0] a;
    logic [3:0]    hi;
    hi = 4'($urandom);
    if (sel) a = wr_list1[$urandom_range(0, wr_list1.size() - 1)];
    else     a = wr_list0[$urandom_range(0, wr_list0.size() - 1)];
    return {hi, a};
  endfunction

  task automatic random_traffic(input int count);
    int nwr;
    for (int i = 0; i < count; i++) begin
      nwr = sel ? wr_list1.size() : wr_list0.size();
      if (nwr == 0 || $urandom_range(0, 1) == 1)
        do_write(16'($urandom), 8'($urandom), int'($urandom_range(0, 4)));
      else
        do_read(pick_addr(), int'($urandom_range(0, 6)), 1'b0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] ab;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(s_ready), 32'd1);
    check("reset_ack", 32'(s_ack), 32'd0);
    check("reset_split_ack", 32'(s_split_ack), 32'd0);
    check("reset_split_req", 32'(split_req), 32'd0);
    check("reset_dvalid", 32'(s_data_out_valid), 32'd0);
    check("reset_dout", 32'(s_data_out), 32'd0);
    check("reset_last_write", 32'(split_s_last_write), 32'd0);
    check("reset_ready_l0", 32'(d0_ready), 32'd1);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Latency-4 instance: directed cases
    do_write(16'h8004, 8'hA5, 0);
    do_read(16'h8004, 0, 1'b0);
    do_read(16'h8004, 10, 1'b0);
    do_write(16'h0123, 8'h3C, 3);
    do_read(16'hF123, 2, 1'b0);
    random_traffic(25);

    // Write aborted by reset: memory must keep its old byte
    abort_write(16'h0004, ~model_mem[0][12'h004]);
    do_read(16'h1004, 1, 1'b0);

    // Reset while waiting for the grant, then normal traffic resumes
    do_read(16'h8004, 0, 1'b1);
    ab = pick_addr();
    do_read(ab, 3, 1'b0);
    do_write(16'h0777, 8'h81, 1);
    do_read(16'h0777, 0, 1'b0);

    // Latency-0 instance
    select(1'b1);
    do_write(16'h1004, 8'h5A, 0);
    do_read(16'h0004, 0, 1'b0);
    random_traffic(12);
    select(1'b0);
    do_read(16'h0777, 4, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
